// File: rtl/fifo_arb_tx_if.sv
// Bundles the two client read ports, the shared output-FIFO write port and the grant.
// No latency of its own; purely a wiring bundle.
// Backpressure is carried by the rdempty/wrfull inputs of the master side.
interface fifo_arb_tx_if #(
  parameter int DWIDTH = 8
);
  logic              c1_rden;
  logic              c1_rdempty;
  logic [DWIDTH-1:0] c1_rddata;
  logic              c2_rden;
  logic              c2_rdempty;
  logic [DWIDTH-1:0] c2_rddata;
  logic              fifo_wren;
  logic              fifo_wrfull;
  logic [DWIDTH-1:0] fifo_wrdata;
  logic [1:0]        grant;

  // Arbiter side
  modport master (
    output c1_rden, input c1_rdempty, input c1_rddata,
    output c2_rden, input c2_rdempty, input c2_rddata,
    output fifo_wren, input fifo_wrfull, output fifo_wrdata,
    output grant
  );

  // Client FIFOs / output FIFO side
  modport slave (
    input c1_rden, output c1_rdempty, output c1_rddata,
    input c2_rden, output c2_rdempty, output c2_rddata,
    input fifo_wren, output fifo_wrfull, input fifo_wrdata,
    input grant
  );
endinterface

// File: rtl/fifo_arb_tx.sv
// Round-robin packet arbiter: moves whole packets from two client FIFOs into one output FIFO.
// Latency: a client read reaches fifo_wren two cycles later at the earliest; header costs one bubble.
// Backpressure: wrfull stalls the 2-entry skid; reads only issue while skid+inflight leaves room.
module fifo_arb_tx #(
  parameter int                DWIDTH  = 8,
  parameter logic [DWIDTH-1:0] SELMASK = DWIDTH'(8'h80),
  parameter logic [DWIDTH-1:0] CNTMASK = DWIDTH'(8'h70)
) (
  input logic            CLK,
  input logic            RESETn,
  fifo_arb_tx_if.master  bus
);

  localparam int CSHIFT = $clog2(CNTMASK) - 3;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_HDR      = 2'd1;
  localparam logic [1:0] S_WAIT_HDR = 2'd2;
  localparam logic [1:0] S_PAYLOAD  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [3:0]        rem_q, rem_d;
  logic [1:0]        grant_q, grant_d;
  logic              last_c2_q, last_c2_d;   // 1 when client 2 owned the last packet
  logic              run_q;                  // holds reads off until the first edge after reset
  logic              infl_q, infl_hdr_q, infl_src_q;
  logic [DWIDTH-1:0] skid_q [0:1];
  logic              wp_q, rp_q;
  logic [1:0]        occ_q;

  logic              rd1, rd2, hdr_rd;
  logic              wren, room, own_empty, pick_c2, any_req;
  logic [2:0]        load;
  logic [2:0]        cnt;
  logic [DWIDTH-1:0] src_dat, push_dat;

  function automatic logic [3:0] decode_len(input logic [2:0] c);
    case (c)
      3'd1:    decode_len = 4'd1;
      3'd2:    decode_len = 4'd2;
      3'd3:    decode_len = 4'd4;
      3'd4:    decode_len = 4'd8;
      default: decode_len = 4'd0;   // 0 and the reserved codes carry no payload
    endcase
  endfunction

  assign wren      = (occ_q != 2'd0) && !bus.fifo_wrfull;
  assign load      = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, wren};
  assign room      = load < 3'd2;
  assign own_empty = grant_q[1] ? bus.c2_rdempty : bus.c1_rdempty;
  assign any_req   = !bus.c1_rdempty || !bus.c2_rdempty;
  assign pick_c2   = !bus.c2_rdempty && (bus.c1_rdempty || !last_c2_q);

  // Data returning from last cycle's read; headers get the client-select bits forced
  always_comb begin
    src_dat  = infl_src_q ? bus.c2_rddata : bus.c1_rddata;
    push_dat = src_dat;
    if (infl_hdr_q) begin
      push_dat = infl_src_q ? (src_dat & ~SELMASK) : (src_dat | SELMASK);
    end
    cnt = 3'((src_dat & CNTMASK) >> CSHIFT);
  end

  // Packet FSM: owner selection, header decode and payload read issue
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    grant_d   = grant_q;
    last_c2_d = last_c2_q;
    rd1       = 1'b0;
    rd2       = 1'b0;
    hdr_rd    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run_q && any_req) begin
          grant_d   = pick_c2 ? 2'b10 : 2'b01;
          last_c2_d = pick_c2;
          if (room) begin
            rd1     = !pick_c2;
            rd2     = pick_c2;
            hdr_rd  = 1'b1;
            state_d = S_HDR;
          end else begin
            state_d = S_WAIT_HDR;
          end
        end
      end
      S_WAIT_HDR: begin
        if (!own_empty && room) begin
          rd1     = grant_q[0];
          rd2     = grant_q[1];
          hdr_rd  = 1'b1;
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        rem_d = decode_len(cnt);
        if (decode_len(cnt) == 4'd0) begin
          state_d = S_IDLE;
          grant_d = 2'b00;
        end else begin
          state_d = S_PAYLOAD;
        end
      end
      default: begin
        if (!own_empty && room) begin
          rd1   = grant_q[0];
          rd2   = grant_q[1];
          rem_d = rem_q - 4'd1;
          if (rem_q == 4'd1) begin
            state_d = S_IDLE;
            grant_d = 2'b00;
          end
        end
      end
    endcase
  end

  // Control state registers
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q    <= S_IDLE;
      rem_q      <= 4'd0;
      grant_q    <= 2'b00;
      last_c2_q  <= 1'b1;
      run_q      <= 1'b0;
      infl_q     <= 1'b0;
      infl_hdr_q <= 1'b0;
      infl_src_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      grant_q    <= grant_d;
      last_c2_q  <= last_c2_d;
      run_q      <= 1'b1;
      infl_q     <= rd1 | rd2;
      infl_hdr_q <= hdr_rd;
      infl_src_q <= rd2;
    end
  end

  // Two-entry skid: captures returning read data, drains into the output FIFO
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      skid_q[0] <= '0;
      skid_q[1] <= '0;
      wp_q      <= 1'b0;
      rp_q      <= 1'b0;
      occ_q     <= 2'd0;
    end else begin
      if (infl_q) begin
        skid_q[wp_q] <= push_dat;
        wp_q         <= ~wp_q;
      end
      if (wren) begin
        rp_q <= ~rp_q;
      end
      occ_q <= occ_q + {1'b0, infl_q} - {1'b0, wren};
    end
  end

  assign bus.c1_rden     = rd1;
  assign bus.c2_rden     = rd2;
  assign bus.fifo_wren   = wren;
  assign bus.fifo_wrdata = skid_q[rp_q];
  assign bus.grant       = grant_q;

endmodule

// File: tb/tb_fifo_arb_tx.sv
// Bench for fifo_arb_tx: queue-based client FIFOs, packet-level expected output stream.
// Directed packets with literal expectations, then randomized packets with random stalls.
// Every cycle: output byte order, full/empty legality, grant ownership and skid room.
module tb_fifo_arb_tx;

  logic CLK = 1'b0;
  logic RESETn = 1'b0;
  always #5 CLK = ~CLK;

  fifo_arb_tx_if #(.DWIDTH(8)) bus ();

  fifo_arb_tx #(.DWIDTH(8), .SELMASK(8'h80), .CNTMASK(8'h70)) dut (
    .CLK(CLK), .RESETn(RESETn), .bus(bus)
  );

  byte unsigned q1[$], q2[$], exp_q[$];
  int  wr_cyc[$];
  int  n_cmp = 0, n_bad = 0;
  int  cyc = 0, wr_count = 0, outstanding = 0;
  int  g_cnt[4];
  bit  s_rd1, s_rd2, rand_mode, full_force, gate1, gate2;
  logic [1:0] prev_g = 2'b00;
  int  npay_tab[8] = '{0, 1, 2, 4, 8, 0, 0, 0};

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output monitor and protocol checks, sampled mid-cycle
  always @(negedge CLK) begin
    cyc++;
    s_rd1 = bus.c1_rden;
    s_rd2 = bus.c2_rden;
    if (RESETn) begin
      g_cnt[bus.grant]++;
      check("rden_exclusive", int'(s_rd1 && s_rd2), 0);
      check("grant_legal", int'(bus.grant == 2'b11), 0);
      if (prev_g != 2'b00 && bus.grant != 2'b00) check("grant_held", bus.grant, prev_g);
      if (s_rd1) check("rd1_nonempty", bus.c1_rdempty, 0);
      if (s_rd2) check("rd2_nonempty", bus.c2_rdempty, 0);
      if (s_rd1 && bus.grant != 2'b00) check("rd1_owner", bus.grant, 1);
      if (s_rd2 && bus.grant != 2'b00) check("rd2_owner", bus.grant, 2);
      if (s_rd1 || s_rd2) check("rd_room", int'((outstanding - int'(bus.fifo_wren)) < 2), 1);
      if (bus.fifo_wren) begin
        check("wren_while_full", bus.fifo_wrfull, 0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL extra_write: got 0x%0h, wanted no write (t=%0t)", bus.fifo_wrdata, $time);
        end else begin
          check("wrdata", bus.fifo_wrdata, exp_q.pop_front());
        end
        wr_cyc.push_back(cyc);
        wr_count++;
      end
      outstanding += int'(s_rd1 || s_rd2) - int'(bus.fifo_wren);
      prev_g = bus.grant;
    end else begin
      prev_g = 2'b00;
    end
  end

  // Client FIFO and output FIFO models: sole driver of the DUT inputs
  initial begin
    bus.c1_rdempty  = 1'b1;
    bus.c2_rdempty  = 1'b1;
    bus.c1_rddata   = 8'h00;
    bus.c2_rddata   = 8'h00;
    bus.fifo_wrfull = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      if (s_rd1 && q1.size() != 0) bus.c1_rddata = q1.pop_front();
      if (s_rd2 && q2.size() != 0) bus.c2_rddata = q2.pop_front();
      gate1 = rand_mode && bus.grant[0] && ($urandom_range(0, 3) == 0);
      gate2 = rand_mode && bus.grant[1] && ($urandom_range(0, 3) == 0);
      bus.c1_rdempty  = (q1.size() == 0) || gate1;
      bus.c2_rdempty  = (q2.size() == 0) || gate2;
      bus.fifo_wrfull = full_force || (rand_mode && ($urandom_range(0, 99) < 30));
    end
  end

  task automatic begin_reset();
    @(posedge CLK);
    #2;
    RESETn = 1'b0;
    q1.delete(); q2.delete(); exp_q.delete(); wr_cyc.delete();
    outstanding = 0;
    wr_count = 0;
    for (int i = 0; i < 4; i++) g_cnt[i] = 0;
  endtask

  task automatic end_reset();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    #1;
    RESETn = 1'b1;
  endtask

  task automatic drain(input string name, input int budget);
    int i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      @(negedge CLK);
      i++;
    end
    repeat (6) @(negedge CLK);
    check(name, exp_q.size(), 0);
    check({name, "_q1_used"}, q1.size(), 0);
    check({name, "_q2_used"}, q2.size(), 0);
  endtask

  task automatic wait_writes(input string name, input int n);
    int i = 0;
    while (wr_count < n && i < 200) begin
      @(negedge CLK);
      i++;
    end
    check(name, int'(wr_count >= n), 1);
  endtask

  // Reference packet generator: client-1 headers gain bit 7, client-2 headers lose it
  task automatic gen_pkt(input int client);
    byte unsigned h, b;
    int n;
    h = 8'($urandom_range(0, 255));
    n = npay_tab[(h >> 4) & 7];
    if (client == 1) begin
      q1.push_back(h);
      exp_q.push_back(h | 8'h80);
    end else begin
      q2.push_back(h);
      exp_q.push_back(h & 8'h7f);
    end
    for (int k = 0; k < n; k++) begin
      b = 8'($urandom_range(0, 255));
      if (client == 1) q1.push_back(b); else q2.push_back(b);
      exp_q.push_back(b);
    end
  endtask

  initial begin
    full_force = 1'b0;
    rand_mode  = 1'b0;

    // 4-byte payload from client 1, one header bubble then contiguous writes
    begin_reset();
    check("reset_wren", bus.fifo_wren, 0);
    check("reset_grant", bus.grant, 0);
    check("reset_wrdata", bus.fifo_wrdata, 0);
    q1 = '{8'h30, 8'h11, 8'h22, 8'h33, 8'h44};
    exp_q = '{8'hb0, 8'h11, 8'h22, 8'h33, 8'h44};
    end_reset();
    drain("t_single", 100);
    check("t_single_nwr", wr_cyc.size(), 5);
    if (wr_cyc.size() == 5) begin
      check("t_single_bubble", wr_cyc[1] - wr_cyc[0], 2);
      for (int i = 2; i < 5; i++) check("t_single_contig", wr_cyc[i] - wr_cyc[i-1], 1);
    end
    check("t_single_no_c2_grant", g_cnt[2], 0);

    // Both clients ready together: client 1 first, then client 2
    begin_reset();
    q1 = '{8'h20, 8'h5a, 8'hc3};
    q2 = '{8'h10, 8'h9e};
    exp_q = '{8'ha0, 8'h5a, 8'hc3, 8'h10, 8'h9e};
    end_reset();
    drain("t_tie", 100);

    // Header-only packet from client 2
    begin_reset();
    q2 = '{8'h85};
    exp_q = '{8'h05};
    end_reset();
    drain("t_hdr_only", 100);
    check("t_hdr_only_grant_cycles", g_cnt[2], 1);
    check("t_hdr_only_no_c1", g_cnt[1], 0);

    // Output full for 5 cycles mid-payload
    begin_reset();
    q1 = '{8'h40, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    exp_q = '{8'hc0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    end_reset();
    wait_writes("t_full_start", 3);
    @(negedge CLK);
    full_force = 1'b1;
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    full_force = 1'b0;
    drain("t_full", 100);

    // Owner runs dry mid-packet while client 2 waits
    begin_reset();
    q1 = '{8'h30, 8'ha1, 8'ha2};
    q2 = '{8'h10, 8'hb1};
    exp_q = '{8'hb0, 8'ha1, 8'ha2, 8'ha3, 8'ha4, 8'h10, 8'hb1};
    end_reset();
    begin
      int i = 0;
      while (q1.size() != 0 && i < 100) begin
        @(negedge CLK);
        i++;
      end
      check("t_starve_drained", q1.size(), 0);
    end
    repeat (10) @(posedge CLK);
    #2;
    q1.push_back(8'ha3);
    q1.push_back(8'ha4);
    drain("t_starve", 100);

    // Reset pulse mid-payload, then a fresh packet
    begin_reset();
    q1 = '{8'h40, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    exp_q = '{8'hc0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    end_reset();
    wait_writes("t_rst_start", 3);
    @(posedge CLK);
    #2;
    RESETn = 1'b0;
    #1;
    check("rst_async_rd1", bus.c1_rden, 0);
    check("rst_async_rd2", bus.c2_rden, 0);
    check("rst_async_wren", bus.fifo_wren, 0);
    check("rst_async_wrdata", bus.fifo_wrdata, 0);
    check("rst_async_grant", bus.grant, 0);
    q1.delete(); q2.delete(); exp_q.delete();
    outstanding = 0;
    q2 = '{8'h21, 8'h77, 8'h88};
    exp_q = '{8'h21, 8'h77, 8'h88};
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    #1;
    RESETn = 1'b1;
    #2;
    check("rst_hold_rd2", bus.c2_rden, 0);
    check("rst_hold_grant", bus.grant, 0);
    drain("t_rst_after", 100);

    // Randomized packets, random full and owner-empty stalls
    for (int r = 0; r < 3; r++) begin
      begin_reset();
      rand_mode = 1'b0;
      for (int k = 0; k < 8; k++) begin
        if (k < 8) gen_pkt(1);
        if (k < 5 + r) gen_pkt(2);
      end
      end_reset();
      rand_mode = 1'b1;
      drain("t_random", 4000);
      rand_mode = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_arb_tx.md
FIFO_ARB_TX -- requirements
Module: fifo_arb_tx

Interface
REQ-001 Parameter SELMASK, default 8'h80: header bits forced to 1 for client-1 packets and to 0 for client-2 packets.
REQ-002 Parameter CNTMASK, default 8'h70: mask of the 3 contiguous count bits; CSHIFT = $clog2(CNTMASK) - 3.
REQ-003 Parameter DWIDTH, default 8: data width.
REQ-004 CLK  input  1  single clock; all state on rising edge.
REQ-005 RESETn  input  1  asynchronous active-low reset.
REQ-006 c1_rden  output  1  read strobe to client-1 FIFO.
REQ-007 c1_rdempty  input  1  client-1 FIFO empty.
REQ-008 c1_rddata  input  DWIDTH  client-1 data; valid the cycle after c1_rden.
REQ-009 c2_rden, c2_rdempty, c2_rddata: same as REQ-006..008 for client 2.
REQ-010 fifo_wren  output  1  write strobe to shared output FIFO.
REQ-011 fifo_wrfull  input  1  output FIFO full.
REQ-012 fifo_wrdata  output  DWIDTH  data to output FIFO.
REQ-013 grant  output  2  one-hot owner of the current packet (bit0 = c1, bit1 = c2); 2'b00 when idle.

Function
REQ-014 Packet = 1 header byte + N payload bytes; N decoded from the count field: 0->0, 1->1, 2->2, 3->4, 4->8, 5..7->0 (reserved).
REQ-015 FSM states: IDLE, HDR, WAIT_HDR, PAYLOAD.
REQ-016 IDLE: if either client is non-empty, pick the owner, set grant, issue the header read and go to HDR; else stay.
REQ-017 Arbitration is round-robin on last_owner: if both clients are non-empty, the client not served last wins; a single requester always wins.
REQ-018 HDR: header data is captured, count decoded into rem (4 bits); next state is PAYLOAD if N>0, else IDLE.
REQ-019 Client-1 header is written as (data | SELMASK); client-2 header is written as (data & ~SELMASK); payload bytes pass unmodified.
REQ-020 PAYLOAD: one read is issued per permitted cycle and rem decrements on each read issue; the FSM goes to IDLE when the last read issues (rem 1->0).
REQ-021 grant stays held across the whole packet; the other client is never read mid-packet.
REQ-022 Owner FIFO empty mid-packet: reads stall, grant is held, no timeout.
REQ-023 Buffering: 2-entry output skid FIFO.
REQ-024 Read issue is permitted only when owner !rdempty and (occupancy + inflight - fifo_wren) < 2; this sustains 1 byte/cycle.
REQ-025 A read issued in cycle N is captured in the skid at the end of cycle N+1 and drives fifo_wren in cycle N+2 at the earliest.
REQ-026 fifo_wren = skid non-empty & !fifo_wrfull; fifo_wrdata = skid head; bytes are never dropped or duplicated.
REQ-027 The header read stalls until the skid has room; a new packet's header may issue in the cycle after the previous packet's last read issues.
REQ-028 c1_rden and c2_rden are never asserted together; rden is never asserted while the corresponding rdempty=1.
REQ-029 Header value 0x00 is a legal 1-byte packet.

Reset
REQ-030 RESETn low asynchronously forces: FSM=IDLE, rem=0, skid empty, inflight=0, last_owner=c2 (so c1 wins first tie), grant=0, c1_rden=c2_rden=fifo_wren=0, fifo_wrdata=0.
REQ-031 Reset mid-packet discards the partial packet and skid contents; after release, the next header is read fresh.
REQ-032 Outputs are stable at reset values until the first rising edge after RESETn is deasserted.

Verification
REQ-033 c1 holds 0x30,A,B,C,D; c2 empty; output never full -> output sequence 0xB0,A,B,C,D; grant=01 throughout; fifo_wren contiguous after the header bubble.
REQ-034 c1 holds 0x20,X,Y; c2 holds 0x10,Z; both non-empty at the same edge after reset -> output 0xA0,X,Y,0x10,Z (c1 first, c2 next).
REQ-035 c2 holds 0x85 with count field 0 -> 1-byte packet; output 0x05; grant=10 for exactly the header cycles.
REQ-036 fifo_wrfull held high for 5 cycles mid-payload -> no fifo_wren during those cycles; no rden once skid occupancy + inflight reaches 2; no loss or duplication afterward.
REQ-037 c1 empties after 2 of 4 payload bytes, then refills 10 cycles later -> grant stays 01; c2 is not read; the packet completes intact.
REQ-038 RESETn pulsed low mid-payload -> all outputs at reset values asynchronously; the next packet after release decodes correctly.
